multi_timer: RTL and testbench
==============================

# multi_timer

Parametrised multi-channel countdown timer on the 6502 8-bit register bus. It generalises the single tick counter to NUM_CH independent channels. Each channel has its own prescaler, a reload value up to 32 bits, periodic or one-shot mode, and a sticky expiry flag. All channel flags merge into one level-sensitive `irq` to the CPU.

## Interface
- NUM_CH, 2, number of channels (1..8)
- CNT_W, 16, counter/reload width in bits (8, 16, 24 or 32)
- ADDR_W, $clog2(NUM_CH)+3, address width (derived, not overridden)

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- cs  in  1  chip select
- rwb  in  1  1 = read, 0 = write
- addr  in  ADDR_W  {channel, register[2:0]}
- i_data  in  8  write data
- o_data  out  8  read data, combinational from addr
- irq  out  1  OR over channels of (EXP & IE), driven from registers

## Operation
- Per-channel register map (offset ch*8):
  - 0..3: reload/count bytes 0..3.
  - 4: PRESCALE.
  - 5: CONTROL.
  - 6: STATUS.
  - 7: reserved, reads 0, writes ignored.
- Bytes at or above CNT_W/8: read 0, writes ignored. Addresses of channels ≥ NUM_CH read 0.
- Reload bytes 1..3 write a staging register.
- Writing byte 0 commits the reload and restarts the channel:
  - reload ← {staging, i_data}
  - count ← reload
  - prescaler ← 0
- Reads of bytes 0..3 return the live count (see Configuration).
- CONTROL:
  - bit0 EN
  - bit1 ONESHOT
  - bit2 IE
  - bits 7:3 read 0
- A write that sets EN from 0 to 1 clears the prescaler. EN=0 freezes both the count and the prescaler.
- STATUS: bit0 EXP, sticky. Writing 1 clears it; writing 0 has no effect.
- Prescaler: counts 0..PRESCALE. At terminal it wraps to 0 and issues one tick, so there is one tick per PRESCALE+1 clocks.
- On a tick with EN=1:
  - count > 1: count decrements.
  - count == 1 (expiry): EXP ← 1 and count ← reload. If ONESHOT=1, EN ← 0.
  - count == 0: no action. Reload value 0 means the channel never expires.
- Simultaneous events:
  - A byte-0 write in the same cycle as a tick: the write wins and the tick is discarded.
  - Expiry in the same cycle as an EXP-clear write: the set wins and EXP stays 1.
  - A CONTROL write in the same cycle as a one-shot expiry: the written EN value wins.
- Reset: all counts, reloads, staging, prescalers, PRESCALE, CONTROL, STATUS and snapshots go to 0. `irq` = 0 and `o_data` = 0 for every address.

## Timing
- Writes take effect on the rising edge where cs & ~rwb. Reads are combinational in the same cycle.
- If the enabling write is at edge N, the first tick is at edge N+PRESCALE+1.
- Periodic channel, reload R: EXP is set every R*(PRESCALE+1) clocks.
- `irq` rises in the cycle after the expiring edge, with no extra register stage. It falls in the cycle after the clearing write or after an IE=0 write.
- Reset is asynchronous on assertion. Deassertion is assumed synchronised upstream.

## Configuration
- MULTI_TIMER_SNAPSHOT_EN defined:
  - A read of byte 0 (cs & rwb at the edge) latches count[CNT_W-1:8] into a per-channel snapshot.
  - Byte 0 reads live; bytes 1..3 return the snapshot, giving coherent multi-byte reads when read low byte first.
- Not defined: no snapshot registers; every byte reads the live count.

## Structure
- Package multi_timer_pkg:
  - register offset localparams (REG_CNT0..REG_CTRL, REG_STAT)
  - CONTROL/STATUS bit-position constants
  - packed struct ctrl_t {en, oneshot, ie}
- Sub-module timer_channel, one instance per channel via generate. It owns the prescaler, count, reload, staging, ctrl, EXP and snapshot.
- Top level does address decode, the o_data mux and the irq OR-reduction.

## Test plan
- Reset mid-countdown (ch0 counting): all registers read 0 and `irq`=0 immediately, without waiting for a clock edge.
- ch0 PRESCALE=3, reload 5, EN|IE: EXP and `irq` rise exactly 20 clocks after the enable write, then every 20 clocks. Writing STATUS=0x01 drops `irq` in the next cycle.
- ch1 ONESHOT|EN, PRESCALE=0, reload 0x0102:
  - EXP sets after 258 clocks.
  - CONTROL reads 0x02 afterwards and count reads 0x0102.
  - No second expiry occurs.
- Snapshot (macro on), count 0x01FF:
  - Read byte 0, then read byte 1 after the count has passed below 0x0100.
  - The two reads return 0xFF and 0x01.
- EXP-clear write on the expiry edge: EXP stays 1. Byte-0 write on a tick edge: count equals the written reload.
- Reload 0 with EN=1 for 1000 clocks: no EXP and `irq` stays 0.

Source files
------------

// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register offsets, CONTROL/STATUS bit positions and the
// per-channel control struct shared by the timer top and its channels.
`timescale 1ns/1ps
package multi_timer_pkg;

   // Per-channel register offsets (low three address bits)
   localparam logic [2:0] REG_CNT0 = 3'd0;
   localparam logic [2:0] REG_CNT1 = 3'd1;
   localparam logic [2:0] REG_CNT2 = 3'd2;
   localparam logic [2:0] REG_CNT3 = 3'd3;
   localparam logic [2:0] REG_PSC  = 3'd4;
   localparam logic [2:0] REG_CTRL = 3'd5;
   localparam logic [2:0] REG_STAT = 3'd6;

   // CONTROL and STATUS bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_ONESHOT = 1;
   localparam int CTRL_IE      = 2;
   localparam int STAT_EXP     = 0;

   // Packed so that the struct bits line up with the CONTROL bit positions
   typedef struct packed {
      logic ie;
      logic oneshot;
      logic en;
   } ctrl_t;

   function automatic ctrl_t ctrl_from_bits(input logic [2:0] d);
      ctrl_t c;
      c.en      = d[CTRL_EN];
      c.oneshot = d[CTRL_ONESHOT];
      c.ie      = d[CTRL_IE];
      return c;
   endfunction

   function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
      logic [7:0] b;
      b               = '0;
      b[CTRL_EN]      = c.en;
      b[CTRL_ONESHOT] = c.oneshot;
      b[CTRL_IE]      = c.ie;
      return b;
   endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// timer_channel: one countdown channel (prescaler, count, reload, staging,
// control, sticky expiry flag). With MULTI_TIMER_SNAPSHOT_EN defined, a read
// of byte 0 latches the upper count bytes so multi-byte reads are coherent.
`timescale 1ns/1ps
module timer_channel
   import multi_timer_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr,
`ifdef MULTI_TIMER_SNAPSHOT_EN
   input  logic       rd,
`endif
   input  logic [2:0] reg_sel,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       irq
);

   localparam int NBYTES = CNT_W / 8;
   localparam int STG_W  = (CNT_W > 8) ? CNT_W - 8 : 8;

   logic [7:0]       prescale;
   logic [7:0]       psc;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] reload;
   logic [STG_W-1:0] staging;
   ctrl_t            ctrl;
   logic             exp_flag;
   logic [CNT_W-1:0] commit_val;
   logic [23:0]      hi_bytes;
   logic             tick;
   logic             expire;
   logic             wr_cnt0;
   logic             wr_ctrl;
   logic             clr_exp;

   assign wr_cnt0 = wr && (reg_sel == REG_CNT0);
   assign wr_ctrl = wr && (reg_sel == REG_CTRL);
   assign clr_exp = wr && (reg_sel == REG_STAT) && i_data[STAT_EXP];
   assign tick    = ctrl.en && (psc == prescale);
   // A byte-0 write on the same edge discards the tick, so no expiry either
   assign expire  = tick && !wr_cnt0 && (count == CNT_W'(1));
   assign irq     = exp_flag & ctrl.ie;

   // Reload value formed from the staged upper bytes and the byte-0 write data
   always_comb begin
      commit_val      = '0;
      commit_val[7:0] = i_data;
      for (int b = 1; b < NBYTES; b++)
         commit_val[b*8 +: 8] = staging[(b-1)*8 +: 8];
   end

   // Prescaler: restarts on byte-0 write or EN rising, frozen while disabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         psc <= '0;
      else if (wr_cnt0)
         psc <= '0;
      else if (wr_ctrl && i_data[CTRL_EN] && !ctrl.en)
         psc <= '0;
      else if (ctrl.en)
         psc <= tick ? 8'd0 : psc + 8'd1;
   end

   // Count and reload: byte-0 write commits and restarts, ticks count down
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         reload <= '0;
      end else if (wr_cnt0) begin
         reload <= commit_val;
         count  <= commit_val;
      end else if (tick && (count != '0)) begin
         count <= (count == CNT_W'(1)) ? reload : count - CNT_W'(1);
      end
   end

   // Staging bytes and PRESCALE register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         staging  <= '0;
         prescale <= '0;
      end else if (wr) begin
         for (int b = 1; b < NBYTES; b++)
            if (reg_sel == 3'(b))
               staging[(b-1)*8 +: 8] <= i_data;
         if (reg_sel == REG_PSC)
            prescale <= i_data;
      end
   end

   // CONTROL: a CONTROL write overrides the one-shot auto-disable
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         ctrl <= '0;
      else if (wr_ctrl)
         ctrl <= ctrl_from_bits(i_data[2:0]);
      else if (expire && ctrl.oneshot)
         ctrl.en <= 1'b0;
   end

   // Sticky expiry flag: a simultaneous expiry beats the clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         exp_flag <= 1'b0;
      else if (expire)
         exp_flag <= 1'b1;
      else if (clr_exp)
         exp_flag <= 1'b0;
   end

`ifdef MULTI_TIMER_SNAPSHOT_EN
   logic [STG_W-1:0] snap;

   // Snapshot of the upper count bytes, taken when byte 0 is read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         snap <= '0;
      else if (rd && (reg_sel == REG_CNT0))
         snap <= STG_W'(count >> 8);
   end

   assign hi_bytes = 24'(snap);
`else
   assign hi_bytes = 24'(count >> 8);
`endif

   // Register read mux; bytes beyond CNT_W come out zero from the padding
   always_comb begin
      o_data = '0;
      case (reg_sel)
         REG_CNT0: o_data = count[7:0];
         REG_CNT1: o_data = hi_bytes[7:0];
         REG_CNT2: o_data = hi_bytes[15:8];
         REG_CNT3: o_data = hi_bytes[23:16];
         REG_PSC:  o_data = prescale;
         REG_CTRL: o_data = ctrl_to_byte(ctrl);
         REG_STAT: o_data = {7'b0, exp_flag};
         default:  o_data = '0;
      endcase
   end

endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH countdown channels on an 8-bit register bus. Decodes
// {channel, register} addresses, muxes read data and ORs channel interrupts.
// Optional coherent multi-byte reads: define MULTI_TIMER_SNAPSHOT_EN.
`timescale 1ns/1ps
module multi_timer
   import multi_timer_pkg::*;
#(
   parameter  int NUM_CH = 2,
   parameter  int CNT_W  = 16,
   localparam int ADDR_W = $clog2(NUM_CH) + 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              rwb,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        i_data,
   output logic [7:0]        o_data,
   output logic              irq
);

   logic [NUM_CH-1:0] ch_irq;
   logic [7:0]        ch_data [NUM_CH];

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic hit;
      assign hit = ((addr >> 3) == ADDR_W'(g));

      timer_channel #(.CNT_W(CNT_W)) u_ch (
         .clk     (clk),
         .reset   (reset),
         .wr      (cs & ~rwb & hit),
`ifdef MULTI_TIMER_SNAPSHOT_EN
         .rd      (cs & rwb & hit),
`endif
         .reg_sel (addr[2:0]),
         .i_data  (i_data),
         .o_data  (ch_data[g]),
         .irq     (ch_irq[g])
      );
   end

   // Read data from the addressed channel; unpopulated channels read zero
   always_comb begin
      o_data = '0;
      for (int i = 0; i < NUM_CH; i++)
         if ((addr >> 3) == ADDR_W'(i))
            o_data = ch_data[i];
   end

   assign irq = |ch_irq;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer (NUM_CH=2, CNT_W=16): directed register traffic, an
// arithmetic model of every channel, a per-cycle irq compare and literal pins.
`timescale 1ns/1ps
module tb_multi_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       cs = 1'b0;
   logic       rwb = 1'b1;
   logic [3:0] addr = '0;
   logic [7:0] i_data = '0;
   logic [7:0] o_data;
   logic       irq;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef MULTI_TIMER_SNAPSHOT_EN
   localparam bit SNAP = 1'b1;
`else
   localparam bit SNAP = 1'b0;
`endif

   always #5 clk = ~clk;

   multi_timer #(.NUM_CH(2), .CNT_W(16)) dut (
      .clk    (clk),
      .reset  (reset),
      .cs     (cs),
      .rwb    (rwb),
      .addr   (addr),
      .i_data (i_data),
      .o_data (o_data),
      .irq    (irq)
   );

   // Model: e = enabled clocks since prescaler restart, t = ticks since reload.
   int m_R [2], m_P [2], m_e [2], m_t [2], m_stg [2], m_snap [2];
   bit m_en [2], m_one [2], m_ie [2], m_exp [2];

   function automatic int m_count(input int ch);
      if (m_R[ch] == 0) return 0;
      return m_R[ch] - (m_t[ch] % m_R[ch]);
   endfunction

   function automatic logic [7:0] m_read(input int ch, input int r);
      case (r)
         0:       return 8'(m_count(ch) & 255);
         1, 2, 3: return SNAP ? 8'((m_snap[ch] >> (8*(r-1))) & 255)
                               : 8'((m_count(ch) >> (8*r)) & 255);
         4:       return 8'(m_P[ch]);
         5:       return {5'b0, m_ie[ch], m_one[ch], m_en[ch]};
         6:       return {7'b0, m_exp[ch]};
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic m_irq();
      return (m_exp[0] & m_ie[0]) | (m_exp[1] & m_ie[1]);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int ch = 0; ch < 2; ch++) begin
            m_R[ch] <= 0; m_P[ch] <= 0; m_e[ch] <= 0; m_t[ch] <= 0;
            m_stg[ch] <= 0; m_snap[ch] <= 0;
            m_en[ch] <= 0; m_one[ch] <= 0; m_ie[ch] <= 0; m_exp[ch] <= 0;
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            bit wr, rd, tick, expire, en, one, ie, ex;
            int R, P, e, t, stg, snap, r, pre;
            R = m_R[ch]; P = m_P[ch]; e = m_e[ch]; t = m_t[ch];
            stg = m_stg[ch]; snap = m_snap[ch];
            en = m_en[ch]; one = m_one[ch]; ie = m_ie[ch]; ex = m_exp[ch];
            pre = m_count(ch);
            r  = int'(addr[2:0]);
            wr = cs && !rwb && (int'(addr[3]) == ch);
            rd = cs && rwb && (int'(addr[3]) == ch);
            tick   = en && (((e + 1) % (P + 1)) == 0);
            expire = tick && (R != 0) && ((t % R) == R - 1) && !(wr && r == 0);
            if (en) e = e + 1;
            if (wr && r == 0) begin
               R = (stg << 8) | int'(i_data); t = 0; e = 0;
            end else if (tick) begin
               t = t + 1;
               if (expire && one) en = 0;
            end
            if (wr && r == 1) stg = int'(i_data);
            if (wr && r == 4) P = int'(i_data);
            if (wr && r == 5) begin
               if (!m_en[ch] && i_data[0]) e = 0;
               en = i_data[0]; one = i_data[1]; ie = i_data[2];
            end
            if (wr && r == 6 && i_data[0]) ex = 0;
            if (expire) ex = 1;
            if (rd && r == 0) snap = pre >> 8;
            m_R[ch] <= R; m_P[ch] <= P; m_e[ch] <= e; m_t[ch] <= t;
            m_stg[ch] <= stg; m_snap[ch] <= snap;
            m_en[ch] <= en; m_one[ch] <= one; m_ie[ch] <= ie; m_exp[ch] <= ex;
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, req, $time);
      end
   endtask

   // irq depends only on state, so compare it every cycle against the model
   always @(negedge clk) check("irq_model", {7'b0, irq}, {7'b0, m_irq()});

   task automatic wr(input int a, input int d);
      cs = 1'b1; rwb = 1'b0; addr = a[3:0]; i_data = d[7:0];
      @(negedge clk);
      cs = 1'b0; rwb = 1'b1;
   endtask

   task automatic rd(input int a, input int lit, input string name);
      cs = 1'b1; rwb = 1'b1; addr = a[3:0];
      #1;
      check({name, "_model"}, o_data, m_read(a >> 3, a & 7));
      check(name, o_data, lit[7:0]);
      @(negedge clk);
      cs = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      idle(3);
      reset = 1'b1;
      for (int a = 0; a < 16; a++) rd(a, 0, "reset_read");

      // ch0 periodic: PRESCALE 3, reload 5, EN|IE -> expiry every 20 clocks
      wr(4, 3); wr(1, 0); wr(0, 5); wr(5, 5);
      idle(19); check("t1_irq_at19", {7'b0, irq}, 8'h00);
      idle(1);  check("t1_irq_at20", {7'b0, irq}, 8'h01);
      rd(6, 1, "t1_exp");
      wr(6, 1); check("t1_irq_cleared", {7'b0, irq}, 8'h00);
      idle(17); check("t1_irq_at39", {7'b0, irq}, 8'h00);
      idle(1);  check("t1_irq_at40", {7'b0, irq}, 8'h01);
      wr(5, 0); wr(6, 1);

      // ch1 one-shot, PRESCALE 0, reload 0x0102 -> single expiry after 258
      wr(12, 0); wr(9, 1); wr(8, 2); wr(13, 3);
      idle(257);
      rd(14, 0, "t2_exp_at257");
      rd(14, 1, "t2_exp_at258");
      rd(13, 2, "t2_ctrl");
      rd(8, 2, "t2_cnt0");
      rd(9, 1, "t2_cnt1");
      wr(14, 1); idle(300);
      rd(14, 0, "t2_no_second");

      // ch0 count 0x01FF: byte 0 read, then byte 1 after dropping below 0x100
      wr(4, 0); wr(1, 1); wr(0, 8'hFF); wr(5, 1);
      rd(0, 8'hFF, "t3_byte0");
      idle(260);
      rd(1, SNAP ? 1 : 0, "t3_byte1");
      wr(5, 0);

      // ch0 EXP-clear on the expiry edge: set wins
      wr(1, 0); wr(0, 3); wr(5, 5);
      idle(2); wr(6, 1);
      check("t4_irq_kept", {7'b0, irq}, 8'h01);
      rd(6, 1, "t4_exp_kept");
      wr(5, 0); wr(6, 1);

      // ch1 byte-0 write on a tick edge: written reload wins
      wr(12, 1); wr(9, 0); wr(8, 10); wr(13, 1);
      idle(1); wr(8, 8'h30);
      rd(8, 8'h30, "t4_wr_wins_b0");
      rd(9, 0, "t4_wr_wins_b1");
      wr(13, 0);

      // ch0 reload 0 with EN|IE: never expires
      wr(1, 0); wr(0, 0); wr(5, 5);
      idle(1000);
      rd(6, 0, "t5_no_exp");
      check("t5_irq_low", {7'b0, irq}, 8'h00);
      wr(5, 0);

      // reset mid-countdown: ch0 periodic reload 2, irq high, then async reset
      wr(0, 2); wr(5, 5);
      idle(3);
      check("t6_irq_before", {7'b0, irq}, 8'h01);
      #2 reset = 1'b0;
      #1 check("t6_irq_reset", {7'b0, irq}, 8'h00);
      for (int a = 0; a < 16; a++) begin
         addr = a[3:0];
         #0.2 check("t6_read_reset", o_data, 8'h00);
      end
      @(negedge clk); reset = 1'b1;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
